receive: RTL and testbench
==========================

RECEIVE -- requirements
Module: receive

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal range is even values 4..65534.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rxd  input  1  serial line from the transmit stage; idle high; asynchronous to clk.
REQ-005 connection_status  input  1  1 = reception enabled, 0 = link down.
REQ-006 word  output  8  last correctly framed received byte.
REQ-007 valid  output  1  one-cycle pulse: word has just been updated.
REQ-008 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-010 rxd SHALL pass through a two-flop synchronizer; all logic uses the synchronized value rxs, which lags rxd by 2 cycles.
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP, plus a bit-period counter and a 3-bit data-bit index.
REQ-013 IDLE -> START when rxs = 0 and connection_status = 1; the counter is cleared on entry.
REQ-014 START: after CLKS_PER_BIT/2 cycles, rxs is resampled; if 0 -> DATA with counter cleared; if 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: every CLKS_PER_BIT cycles one bit is sampled into a shift register (first sample = bit 0); after the 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles rxs is sampled, then the FSM returns to IDLE on the next cycle.
REQ-017 Stop sample = 1: in the cycle after the sample, word <= shift register and valid = 1 for exactly one cycle.
REQ-018 Stop sample = 0: frame_error = 1 for exactly one cycle, word unchanged, valid stays 0.
REQ-019 valid and frame_error SHALL never be 1 in the same cycle.
REQ-020 word SHALL hold its value between valid pulses.
REQ-021 connection_status = 0 in any non-IDLE state SHALL abort to IDLE on the next edge with no valid or frame_error pulse; word is unchanged.
REQ-022 A new start bit SHALL be accepted in the first IDLE cycle after STOP; back-to-back frames are received without loss.
REQ-023 rxs held low continuously after a frame_error SHALL be treated as a new start edge, with the usual START glitch check.
REQ-024 Counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits; the counter never wraps inside a bit period.

Reset
REQ-025 While rst = 0: state = IDLE, word = 8'h00, valid = 0, frame_error = 0, busy = 0, both synchronizer flops = 1, counter, index and shift register = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately; no pulse is emitted after release.
REQ-027 After rst rises, the first frame SHALL be received normally; a line held low through reset release is treated as a start edge.

Verification (CLKS_PER_BIT = 16, clk period 2 ns)
REQ-028 Frame 0x81 (129) with connection_status = 1 -> word = 8'h81, valid high for 1 cycle, frame_error = 0, busy = 0 afterwards.
REQ-029 Frames 0x01 then 0xA5 back-to-back with no idle gap -> two valid pulses, with word = 8'h01 then 8'hA5.
REQ-030 rxd pulsed low for 3 clk cycles, then high -> no valid pulse, busy returns to 0 within 10 cycles, word unchanged.
REQ-031 Frame 0x3C with stop bit driven 0 -> one frame_error pulse, valid = 0, word keeps its previous value.
REQ-032 connection_status dropped during data bit 4 -> busy = 0 on the next cycle, no pulses; a following frame 0x55 is received correctly.
REQ-033 rst pulsed low during data bit 2 -> all outputs at reset values, no pulse after release; a next frame 0xFF gives word = 8'hFF.

Source files
------------

// File: rtl/receive.sv
// UART receiver: 2-flop synchronized rxd, start-bit glitch check, 8N1 framing, word/valid/frame_error outputs.
// Latency: word/valid (or frame_error) appear one cycle after the mid-stop-bit sample.
// Backpressure: none; pulses are single-cycle, and connection_status=0 aborts any frame in progress.
//
// Ports:
//   clk                system clock (rising edge)
//   rst                asynchronous active-low reset
//   rxd                serial line, idle high, asynchronous to clk
//   connection_status  1 = reception enabled, 0 = link down (aborts frame)
//   word               last correctly framed byte, held between valid pulses
//   valid              one-cycle pulse, word just updated
//   frame_error        one-cycle pulse, stop bit sampled low
//   busy               receiver is not IDLE
module receive #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       connection_status,
    output logic [7:0] word,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      word_q, word_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Link down while in a frame throws the frame away.
    logic abort;
    assign abort = (state_q != IDLE) && !connection_status;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs_q && connection_status) state_d = START;
            end
            START: begin
                // Line back high at mid start bit means it was a glitch.
                if (cnt_q == HALF_LAST) state_d = rxs_q ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_q == BIT_LAST && idx_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (cnt_q == BIT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Datapath: bit counter, bit index, shift register and result registers
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START: begin
                cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + 1'b1;
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rxs_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
        if (abort) begin
            cnt_d   = '0;
            idx_d   = '0;
            word_d  = word_q;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        word        = word_q;
        valid       = valid_q;
        frame_error = ferr_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_receive.sv
// Self-checking bench for receive: directed frames plus randomized frames against a frame-level model.
// Latency: events are matched in order via an expected-event queue, not cycle by cycle.
// Backpressure: none; the bench drives rxd/connection_status on falling edges and samples on falling edges.
module tb_receive;

    localparam int CPB = 16;
    localparam int EV_FERR = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       cs  = 1'b1;
    logic [7:0] word;
    logic       valid;
    logic       frame_error;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Model: ordered list of expected output events (byte value, or EV_FERR),
    // and the value word must hold once the line is idle.
    int   exp_q[$];
    int   exp_word = 0;
    logic prev_pulse = 1'b0;
    int   mon_exp;
    int   mon_obs;

    receive #(.CLKS_PER_BIT(CPB)) dut (
        .clk               (clk),
        .rst               (rst),
        .rxd               (rxd),
        .connection_status (cs),
        .word              (word),
        .valid             (valid),
        .frame_error       (frame_error),
        .busy              (busy)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every output pulse must be the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            prev_pulse = 1'b0;
        end else begin
            if (valid || frame_error) begin
                chk("pulse_excl", int'(valid & frame_error), 0);
                chk("pulse_width", int'(prev_pulse), 0);
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                mon_obs = valid ? int'(word) : EV_FERR;
                chk("rx_event", mon_obs, mon_exp);
            end
            prev_pulse = valid | frame_error;
        end
    end

    // kind: 0 normal, 1 link drop in bit ev_bit, 2 reset pulse in bit ev_bit,
    //       3 reset held (by caller) through the start of the start bit.
    // Bit indices: 0 = start, 1..8 = data bits 0..7, 9 = stop.
    task automatic send_frame(input logic [7:0] data, input logic stop_b,
                              input int kind, input int ev_bit, input int gap_bits);
        logic [9:0] bits;
        bits = {stop_b, data, 1'b0};
        if (kind == 0 || kind == 3) begin
            exp_q.push_back(stop_b ? int'(data) : EV_FERR);
            if (stop_b) exp_word = int'(data);
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0) rxd = bits[b];
                if (b == 1 && c == 0) chk("busy_in_frame", int'(busy), 1);
                if (kind == 3 && b == 0 && c == 4) rst = 1'b1;
                if (kind == 1 && b == ev_bit && c == 4) begin
                    chk("busy_before_drop", int'(busy), 1);
                    cs = 1'b0;
                end
                if (kind == 1 && b == ev_bit && c == 5) chk("busy_after_drop", int'(busy), 0);
                if (kind == 2 && b == ev_bit && c == 4) begin
                    rst = 1'b0;
                    exp_word = 0;
                end
                if (kind == 2 && b == ev_bit && c == 5) begin
                    chk("rst_word", int'(word), 0);
                    chk("rst_valid", int'(valid), 0);
                    chk("rst_ferr", int'(frame_error), 0);
                    chk("rst_busy", int'(busy), 0);
                end
                if (kind == 2 && b == ev_bit + 1 && c == 4) rst = 1'b1;
                @(negedge clk);
            end
        end
        rxd = 1'b1;
        repeat (gap_bits * CPB) @(negedge clk);
        cs = 1'b1;
        chk("pending", exp_q.size(), 0);
        chk("word_hold", int'(word), exp_word);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        logic [7:0] d;
        int         r;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_word", int'(word), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_ferr", int'(frame_error), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Single frame
        send_frame(8'h81, 1'b1, 0, 0, 2);

        // Back-to-back frames, no idle gap
        send_frame(8'h01, 1'b1, 0, 0, 0);
        send_frame(8'hA5, 1'b1, 0, 0, 2);

        // Short low glitch must be rejected
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        chk("glitch_busy", int'(busy), 1);
        repeat (9) @(negedge clk);
        chk("glitch_idle", int'(busy), 0);
        repeat (CPB) @(negedge clk);
        chk("glitch_word", int'(word), exp_word);

        // Bad stop bit
        send_frame(8'h3C, 1'b0, 0, 0, 2);

        // Link drop during data bit 4, then a clean frame
        send_frame(8'h96, 1'b1, 1, 5, 1);
        send_frame(8'h55, 1'b1, 0, 0, 1);

        // Reset during data bit 2; remaining bits are high so nothing restarts
        send_frame(8'hFA, 1'b1, 2, 3, 1);
        send_frame(8'hFF, 1'b1, 0, 0, 1);

        // Line already low at reset release counts as a start edge
        rst = 1'b0;
        send_frame(8'h6E, 1'b1, 3, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            if (r == 0)
                send_frame(d, 1'b1, 1, int'($urandom_range(1, 9)), 1);
            else if (r == 1)
                send_frame(d, 1'b0, 0, 0, int'($urandom_range(1, 3)));
            else
                send_frame(d, 1'b1, 0, 0, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
